// File: rtl/alu_ops_pkg.sv
// Shared ALU op codes, MULTU/DIVU selector values and the multiply/divide
// sequencer state encoding.
package alu_ops_pkg;

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluXor = 3'b011,
    AluSub = 3'b110,
    AluSlt = 3'b111
  } alu_op_e;

  localparam logic MdMultu = 1'b0;
  localparam logic MdDivu  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StMulAdd,
    StMulCry,
    StDivCmp,
    StDivSub,
    StDone
  } md_state_e;

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU engine that has no adder of its own; it
// borrows the shared ALU for every add, subtract and unsigned compare.
module muldiv_sequencer
  import alu_ops_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             alu_sel,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             lt_q, lt_d;
  alu_op_e          op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             last;
  logic             iter_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      sum_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      sum_q   <= sum_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    q_d      = q_q;
    m_d      = m_q;
    sum_d    = sum_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    lt_d     = lt_q;
    op       = AluAnd;
    opa      = '0;
    opb      = '0;
    iter_end = 1'b0;
    last     = (cnt_q == CNT_W'(WIDTH - 1));

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          q_d     = rs_val;
          m_d     = rt_val;
          cnt_d   = '0;
          state_d = (md_op == MdDivu) ? StDivCmp : StMulAdd;
        end
      end
      StMulAdd: begin
        op      = AluAdd;
        opa     = acc_q;
        opb     = m_q;
        sum_d   = alu_result;
        state_d = StMulCry;
      end
      StMulCry: begin
        // Unsigned sum < addend means the add wrapped: that is the carry out.
        op  = AluSlt;
        opa = sum_q;
        opb = m_q;
        if (q_q[0]) begin
          {acc_d, q_d} = {alu_result[0], sum_q, q_q[WIDTH-1:1]};
        end else begin
          {acc_d, q_d} = {1'b0, acc_q, q_q[WIDTH-1:1]};
        end
        iter_end = 1'b1;
      end
      StDivCmp: begin
        op      = AluSlt;
        opa     = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
        opb     = m_q;
        ovf_d   = acc_q[WIDTH-1];
        acc_d   = opa;
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        lt_d    = alu_result[0];
        state_d = StDivSub;
      end
      StDivSub: begin
        // A bit shifted out of acc means the true remainder exceeds m.
        op  = AluSub;
        opa = acc_q;
        opb = m_q;
        if (ovf_q || !lt_q) begin
          acc_d  = alu_result;
          q_d[0] = 1'b1;
        end
        iter_end = 1'b1;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (iter_end) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        state_d = StDone;
        hi_d    = acc_d;
        lo_d    = q_d;
      end else begin
        state_d = (state_q == StDivSub) ? StDivCmp : StMulAdd;
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign alu_sel = (state_q != StIdle) && (state_q != StDone);
  assign done    = (state_q == StDone);
  assign alu_op  = op;
  assign alu_a   = opa;
  assign alu_b   = opb;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
